// File: rtl/nap_pkg.sv
// Shared nap-flow state encoding and default timing constants, used by the nap
// timer, main_state and the display block.
package nap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    COUNT  = 2'd2,
    RING   = 2'd3
  } napState_t;

  localparam int SEC_PER_MIN          = 60;
  localparam int DEF_TICKS_PER_SEC    = 50000000;
  localparam int DEF_MIN_W            = 7;
  localparam int DEF_MAX_MIN          = 99;
  localparam int DEF_SNOOZE_MIN       = 5;
  localparam int DEF_MAX_SNOOZE       = 3;
  localparam int DEF_BEEP_HALF        = 25000000;
  localparam int DEF_RING_TIMEOUT_SEC = 60;

endpackage

// File: rtl/nap_tick_prescaler.sv
// Cycle prescaler with enable and clear; emits a one-cycle tick every TICKS
// enabled cycles and holds its count while disabled.
module nap_tick_prescaler #(
  parameter int TICKS = 50000000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [CW-1:0] countR;

  assign tick = enable && !clear && (countR == CW'(TICKS - 1));

  // Cycle counter: clear wins, wraps on tick, freezes while disabled.
  always_ff @(posedge clock) begin
    if (reset) begin
      countR <= {CW{1'b0}};
    end else if (clear || tick) begin
      countR <= {CW{1'b0}};
    end else if (enable) begin
      countR <= countR + CW'(1);
    end else begin
      countR <= countR;
    end
  end

endmodule

// File: rtl/nap_timer_ctrl.sv
// Nap countdown and alarm sequencer: holds the chosen duration, counts it down
// while enSleep is high, then rings with snooze, cancel and ring timeout.
module nap_timer_ctrl
  import nap_pkg::*;
#(
  parameter int TICKS_PER_SEC    = DEF_TICKS_PER_SEC,
  parameter int MIN_W            = DEF_MIN_W,
  parameter int MAX_MIN          = DEF_MAX_MIN,
  parameter int SNOOZE_MIN       = DEF_SNOOZE_MIN,
  parameter int MAX_SNOOZE       = DEF_MAX_SNOOZE,
  parameter int BEEP_HALF        = DEF_BEEP_HALF,
  parameter int RING_TIMEOUT_SEC = DEF_RING_TIMEOUT_SEC
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [MIN_W-1:0] load_min,
  input  logic             enSleep,
  input  logic             cancel,
  input  logic             snooze,
  output logic             completeSleep,
  output logic             buzzer,
  output logic [MIN_W-1:0] remain_min,
  output logic [5:0]       remain_sec,
  output logic             busy,
  output logic [1:0]       snooze_count,
  output logic             timed_out
);

  localparam int RING_W = (RING_TIMEOUT_SEC > 1) ? $clog2(RING_TIMEOUT_SEC) : 1;
  localparam int BEEP_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

  napState_t         stateR;
  logic [RING_W-1:0] ringSecR;
  logic [BEEP_W-1:0] beepCntR;

  logic             secTickS;
  logic             ringTickS;
  logic             countEnS;
  logic             countClrS;
  logic             ringEnS;
  logic             ringClrS;
  logic             loadOkS;
  logic             snoozeOkS;
  logic             ringTimeoutS;
  logic             abortS;
  logic             lastSecS;
  logic [MIN_W-1:0] loadClampS;

  assign countEnS     = (stateR == COUNT) && enSleep;
  assign countClrS    = (stateR != COUNT) || cancel;
  assign ringEnS      = (stateR == RING);
  assign ringClrS     = (stateR != RING) || cancel;
  assign loadOkS      = load_valid && (load_min != {MIN_W{1'b0}}) &&
                        ((stateR == IDLE) || (stateR == LOADED));
  assign loadClampS   = (load_min > MIN_W'(MAX_MIN)) ? MIN_W'(MAX_MIN) : load_min;
  assign snoozeOkS    = snooze && (snooze_count < 2'(MAX_SNOOZE));
  assign ringTimeoutS = ringTickS && (ringSecR == RING_W'(RING_TIMEOUT_SEC - 1));
  // A valid snooze beats the timeout tick; cancel beats everything.
  assign abortS       = cancel || ((stateR == RING) && !snoozeOkS && ringTimeoutS);
  assign lastSecS     = (remain_min == {MIN_W{1'b0}}) && (remain_sec == 6'd1);

  nap_tick_prescaler #(
    .TICKS (TICKS_PER_SEC)
  ) uCountPrescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (countEnS),
    .clear  (countClrS),
    .tick   (secTickS)
  );

  nap_tick_prescaler #(
    .TICKS (TICKS_PER_SEC)
  ) uRingPrescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (ringEnS),
    .clear  (ringClrS),
    .tick   (ringTickS)
  );

  // Nap sequencer: state, remaining time, alarm outputs and snooze bookkeeping.
  always_ff @(posedge clock) begin
    if (reset || abortS) begin
      stateR        <= IDLE;
      remain_min    <= {MIN_W{1'b0}};
      remain_sec    <= 6'd0;
      snooze_count  <= 2'd0;
      completeSleep <= 1'b0;
      buzzer        <= 1'b0;
      busy          <= 1'b0;
      ringSecR      <= {RING_W{1'b0}};
      beepCntR      <= {BEEP_W{1'b0}};
      timed_out     <= !reset && !cancel;
    end else begin
      timed_out <= 1'b0;
      case (stateR)
        IDLE, LOADED: begin
          if (loadOkS) begin
            stateR       <= LOADED;
            remain_min   <= loadClampS;
            remain_sec   <= 6'd0;
            snooze_count <= 2'd0;
            busy         <= 1'b1;
          end else if ((stateR == LOADED) && enSleep) begin
            stateR <= COUNT;
          end else begin
            stateR <= stateR;
          end
        end
        COUNT: begin
          if (secTickS) begin
            if (lastSecS) begin
              stateR        <= RING;
              remain_sec    <= 6'd0;
              completeSleep <= 1'b1;
              buzzer        <= 1'b1;
              beepCntR      <= {BEEP_W{1'b0}};
              ringSecR      <= {RING_W{1'b0}};
            end else if (remain_sec == 6'd0) begin
              remain_min <= remain_min - MIN_W'(1);
              remain_sec <= 6'(SEC_PER_MIN - 1);
            end else begin
              remain_sec <= remain_sec - 6'd1;
            end
          end
        end
        RING: begin
          if (snoozeOkS) begin
            stateR        <= COUNT;
            remain_min    <= MIN_W'(SNOOZE_MIN);
            remain_sec    <= 6'd0;
            snooze_count  <= snooze_count + 2'd1;
            completeSleep <= 1'b0;
            buzzer        <= 1'b0;
          end else begin
            if (ringTickS) begin
              ringSecR <= ringSecR + RING_W'(1);
            end
            if (beepCntR == BEEP_W'(BEEP_HALF - 1)) begin
              beepCntR <= {BEEP_W{1'b0}};
              buzzer   <= !buzzer;
            end else begin
              beepCntR <= beepCntR + BEEP_W'(1);
            end
          end
        end
        default: begin
          stateR <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nap_timer_ctrl.sv
// Self-checking bench for nap_timer_ctrl: directed scenarios plus randomized
// traffic, all checked against a total-seconds behavioural model.
module tb_nap_timer_ctrl;

  localparam int TPS  = 4;
  localparam int BEEP = 2;
  localparam int SNZ  = 1;
  localparam int MAXS = 3;
  localparam int RTO  = 3;
  localparam int MAXM = 99;

  localparam int M_IDLE   = 0;
  localparam int M_LOADED = 1;
  localparam int M_COUNT  = 2;
  localparam int M_RING   = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_valid = 1'b0;
  logic [6:0] load_min = 7'd0;
  logic       enSleep = 1'b0;
  logic       cancel = 1'b0;
  logic       snooze = 1'b0;
  logic       completeSleep;
  logic       buzzer;
  logic [6:0] remain_min;
  logic [5:0] remain_sec;
  logic       busy;
  logic [1:0] snooze_count;
  logic       timed_out;
  logic [18:0] dutOut;

  int nCmp = 0;
  int nBad = 0;

  int   mMode, mRem, mPhase, mSnz, mRingCyc;
  logic mTimedOut;

  nap_timer_ctrl #(
    .TICKS_PER_SEC    (TPS),
    .MIN_W            (7),
    .MAX_MIN          (MAXM),
    .SNOOZE_MIN       (SNZ),
    .MAX_SNOOZE       (MAXS),
    .BEEP_HALF        (BEEP),
    .RING_TIMEOUT_SEC (RTO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .load_valid    (load_valid),
    .load_min      (load_min),
    .enSleep       (enSleep),
    .cancel        (cancel),
    .snooze        (snooze),
    .completeSleep (completeSleep),
    .buzzer        (buzzer),
    .remain_min    (remain_min),
    .remain_sec    (remain_sec),
    .busy          (busy),
    .snooze_count  (snooze_count),
    .timed_out     (timed_out)
  );

  assign dutOut = {completeSleep, buzzer, remain_min, remain_sec, busy, snooze_count, timed_out};

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic modelClear();
    mMode = M_IDLE; mRem = 0; mPhase = 0; mSnz = 0; mRingCyc = 0;
  endtask

  // Model keeps remaining time as a total second count and ring time as cycles.
  task automatic modelStep(input logic rs, input logic lv, input logic [6:0] lm,
                           input logic es, input logic ca, input logic sn);
    mTimedOut = 1'b0;
    if (rs || ca) begin
      modelClear();
    end else if ((mMode == M_IDLE || mMode == M_LOADED) && lv && lm != 7'd0) begin
      mRem  = ((int'(lm) > MAXM) ? MAXM : int'(lm)) * 60;
      mSnz  = 0;
      mMode = M_LOADED;
    end else if (mMode == M_LOADED) begin
      if (es) begin mMode = M_COUNT; mPhase = 0; end
    end else if (mMode == M_COUNT) begin
      if (es) begin
        mPhase++;
        if (mPhase == TPS) begin
          mPhase = 0;
          mRem--;
          if (mRem == 0) begin mMode = M_RING; mRingCyc = 0; end
        end
      end
    end else if (mMode == M_RING) begin
      if (sn && mSnz < MAXS) begin
        mSnz++; mRem = SNZ * 60; mMode = M_COUNT; mPhase = 0;
      end else if (mRingCyc == RTO * TPS - 1) begin
        modelClear(); mTimedOut = 1'b1;
      end else begin
        mRingCyc++;
      end
    end
  endtask

  function automatic logic [18:0] modelOut();
    logic ring;
    ring = (mMode == M_RING);
    return {ring, ring && (((mRingCyc / BEEP) % 2) == 0), 7'(mRem / 60), 6'(mRem % 60),
            (mMode != M_IDLE), 2'(mSnz), mTimedOut};
  endfunction

  task automatic cyc(input logic lv, input logic [6:0] lm, input logic es,
                     input logic ca, input logic sn);
    load_valid = lv; load_min = lm; enSleep = es; cancel = ca; snooze = sn;
    @(posedge clock);
    modelStep(reset, lv, lm, es, ca, sn);
    #1;
  endtask

  task automatic runToRing(input int limit, output int n);
    n = 0;
    while (completeSleep !== 1'b1 && n < limit) begin
      cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
      n++;
      nCmp++;
      if (dutOut !== modelOut()) begin
        nBad++; $display("FAIL run_model: got %h expected %h", dutOut, modelOut());
      end
    end
    nCmp++;
    if (completeSleep !== 1'b1) begin
      nBad++; $display("FAIL run_to_ring_bound: got completeSleep %b expected 1", completeSleep);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(1'b1, 7'd5, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    nCmp++;
    if (dutOut !== 19'h0) begin
      nBad++; $display("FAIL reset_outputs: got %h expected %h", dutOut, 19'h0);
    end
    reset = 1'b0;
  endtask

  task automatic test_load_run();
    int n;
    logic [0:5] pat;
    pat = 6'b110011;
    cyc(1'b1, 7'd1, 1'b0, 1'b0, 1'b0);
    nCmp++;
    if ({busy, remain_min, remain_sec} !== {1'b1, 7'd1, 6'd0}) begin
      nBad++; $display("FAIL load_latency: got %b/%0d:%0d expected 1/1:0", busy, remain_min, remain_sec);
    end
    cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (completeSleep !== 1'b1 && n < 400) begin
      cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
      n++;
      if (n == 4) begin
        nCmp++;
        if ({remain_min, remain_sec} !== {7'd0, 6'd59}) begin
          nBad++; $display("FAIL first_second: got %0d:%0d expected 0:59", remain_min, remain_sec);
        end
      end
      nCmp++;
      if (dutOut !== modelOut()) begin
        nBad++; $display("FAIL count_model: got %h expected %h", dutOut, modelOut());
      end
    end
    nCmp++;
    if (n != 240) begin
      nBad++; $display("FAIL ring_latency: got %0d expected 240", n);
    end
    for (int k = 0; k < 6; k++) begin
      nCmp++;
      if (buzzer !== pat[k] || completeSleep !== 1'b1) begin
        nBad++; $display("FAIL buzzer_pattern[%0d]: got %b expected %b", k, buzzer, pat[k]);
      end
      cyc(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_pause();
    int n;
    logic es;
    cyc(1'b1, 7'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (completeSleep !== 1'b1 && n < 400) begin
      es = !(n >= 101 && n <= 110);
      cyc(1'b0, 7'd0, es, 1'b0, 1'b0);
      n++;
      nCmp++;
      if (dutOut !== modelOut()) begin
        nBad++; $display("FAIL pause_model: got %h expected %h", dutOut, modelOut());
      end
    end
    nCmp++;
    if (n != 250) begin
      nBad++; $display("FAIL pause_span: got %0d expected 250", n);
    end
    cyc(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_cancel();
    int n;
    cyc(1'b1, 7'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (mRem != 30 && n < 400) begin
      cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
      n++;
    end
    cyc(1'b0, 7'd0, 1'b1, 1'b1, 1'b0);
    nCmp++;
    if ({busy, remain_min, remain_sec, completeSleep} !== {1'b0, 7'd0, 6'd0, 1'b0}) begin
      nBad++; $display("FAIL cancel_count: got busy %b %0d:%0d expected busy 0 0:0", busy, remain_min, remain_sec);
    end
    cyc(1'b1, 7'd1, 1'b0, 1'b0, 1'b0);
    runToRing(400, n);
    cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b1);
    runToRing(400, n);
    cyc(1'b0, 7'd0, 1'b1, 1'b1, 1'b1);
    nCmp++;
    if ({busy, snooze_count, completeSleep, buzzer} !== {1'b0, 2'd0, 1'b0, 1'b0}) begin
      nBad++; $display("FAIL cancel_with_snooze: got busy %b snz %0d expected busy 0 snz 0", busy, snooze_count);
    end
  endtask

  task automatic test_snooze_limit();
    int n;
    cyc(1'b1, 7'd1, 1'b0, 1'b0, 1'b0);
    runToRing(400, n);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b1);
      if (k <= 3) begin
        nCmp++;
        if ({snooze_count, completeSleep, buzzer, remain_min, remain_sec} !== {2'(k), 1'b0, 1'b0, 7'd1, 6'd0}) begin
          nBad++; $display("FAIL snooze_%0d: got snz %0d ring %b %0d:%0d expected snz %0d ring 0 1:0",
                           k, snooze_count, completeSleep, remain_min, remain_sec, k);
        end
        runToRing(400, n);
      end else begin
        nCmp++;
        if ({snooze_count, completeSleep} !== {2'd3, 1'b1}) begin
          nBad++; $display("FAIL snooze_limit: got snz %0d ring %b expected snz 3 ring 1", snooze_count, completeSleep);
        end
      end
    end
    cyc(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int n;
    cyc(1'b1, 7'd1, 1'b0, 1'b0, 1'b0);
    runToRing(400, n);
    n = 0;
    while (timed_out !== 1'b1 && n < 50) begin
      cyc(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    nCmp++;
    if (n != 12 || busy !== 1'b0 || completeSleep !== 1'b0) begin
      nBad++; $display("FAIL timeout_latency: got %0d busy %b expected 12 busy 0", n, busy);
    end
    cyc(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    nCmp++;
    if (timed_out !== 1'b0) begin
      nBad++; $display("FAIL timeout_pulse_width: got %b expected 0", timed_out);
    end
  endtask

  task automatic test_load_edges();
    int n;
    cyc(1'b1, 7'd0, 1'b0, 1'b0, 1'b0);
    nCmp++;
    if (busy !== 1'b0) begin
      nBad++; $display("FAIL load_zero: got busy %b expected 0", busy);
    end
    cyc(1'b1, 7'd120, 1'b0, 1'b0, 1'b0);
    nCmp++;
    if ({busy, remain_min, remain_sec} !== {1'b1, 7'd99, 6'd0}) begin
      nBad++; $display("FAIL load_clamp: got %0d:%0d expected 99:0", remain_min, remain_sec);
    end
    for (int k = 0; k < 6; k++) cyc(1'b0, 7'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 7'd5, 1'b1, 1'b0, 1'b0);
    nCmp++;
    if ({remain_min, remain_sec} !== {7'd98, 6'd59} || dutOut !== modelOut()) begin
      nBad++; $display("FAIL load_in_count: got %0d:%0d expected 98:59", remain_min, remain_sec);
    end
    cyc(1'b0, 7'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 7'd1, 1'b0, 1'b0, 1'b0);
    runToRing(400, n);
    cyc(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 7'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    nCmp++;
    if (dutOut !== 19'h0) begin
      nBad++; $display("FAIL reset_in_ring: got %h expected %h", dutOut, 19'h0);
    end
  endtask

  task automatic test_random();
    logic lv, es, ca, sn;
    logic [6:0] lm;
    for (int i = 0; i < 3000; i++) begin
      lv = ($urandom_range(0, 19) == 0);
      lm = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 2));
      es = ($urandom_range(0, 9) != 0);
      ca = ($urandom_range(0, 299) == 0);
      sn = ($urandom_range(0, 7) == 0);
      cyc(lv, lm, es, ca, sn);
      nCmp++;
      if (dutOut !== modelOut()) begin
        nBad++; $display("FAIL random_cycle_%0d: got %h expected %h", i, dutOut, modelOut());
      end
    end
  endtask

  initial begin
    modelClear();
    mTimedOut = 1'b0;
    test_reset();
    test_load_run();
    test_pause();
    test_cancel();
    test_snooze_limit();
    test_timeout();
    test_load_edges();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
